// File: rtl/fetch_pkg.sv
// Shared CPU definitions used by the fetch stage.
// Holds the reset PC, the NOP encoding and the fetch FSM encoding.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding imem read, a single
// instruction register toward decode, and redirect handling.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] ir_pc,
  output logic [31:0] pc_plus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  ir_q, ir_d;
  logic         vld_q, vld_d;
  logic [31:0]  irpc_q, irpc_d;
  logic [31:0]  p4_q, p4_d;
  logic [31:0]  tgt;

  assign tgt = {pc_target[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    irpc_d  = irpc_q;
    p4_d    = p4_q;
    unique case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_d  = tgt;
          vld_d = 1'b0;
        end else begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ, DRAIN: begin
        if (imem_ack && pc_load) begin
          // Redirect lands with the ack: drop data, reissue at target.
          addr_d  = tgt;
          pc_d    = tgt;
          state_d = REQ;
        end else if (imem_ack) begin
          if (state_q == REQ) begin
            ir_d    = imem_data;
            irpc_d  = addr_q;
            p4_d    = addr_q + 32'd4;
            vld_d   = 1'b1;
            pc_d    = addr_q + 32'd4;
            req_d   = 1'b0;
            state_d = FULL;
          end else begin
            addr_d  = pc_q;
            state_d = REQ;
          end
        end else if (pc_load) begin
          pc_d    = tgt;
          state_d = DRAIN;
        end
      end
      FULL: begin
        if (pc_load) begin
          pc_d    = tgt;
          vld_d   = 1'b0;
          state_d = IDLE;
        end else if (!stall) begin
          vld_d   = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      ir_q    <= NOP;
      vld_q   <= 1'b0;
      irpc_q  <= 32'h0000_0000;
      p4_q    <= 32'h0000_0004;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
      irpc_q  <= irpc_d;
      p4_q    <= p4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign ir_valid  = vld_q;
  assign ir_pc     = irpc_q;
  assign pc_plus4  = p4_q;

endmodule

// File: tb/tb_fetch.sv
// Directed cycle-by-cycle vectors for the fetch stage, plus a
// second instance exercising PC wrap from RESET_PC=FFFF_FFFC.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst, ack, stall, ld;
  logic [31:0] data, tgt;
  logic        req, vld;
  logic [31:0] addr, ir, irpc, p4;

  logic        w_rst, w_ack, w_stall, w_ld;
  logic [31:0] w_data, w_tgt;
  logic        w_req, w_vld;
  logic [31:0] w_addr, w_ir, w_irpc, w_p4;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  fetch u_dut (
    .clk(clk), .rst(rst),
    .imem_req(req), .imem_addr(addr),
    .imem_ack(ack), .imem_data(data),
    .stall(stall), .pc_load(ld), .pc_target(tgt),
    .ir(ir), .ir_valid(vld), .ir_pc(irpc), .pc_plus4(p4)
  );

  fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_data(w_data),
    .stall(w_stall), .pc_load(w_ld), .pc_target(w_tgt),
    .ir(w_ir), .ir_valid(w_vld), .ir_pc(w_irpc), .pc_plus4(w_p4)
  );

  typedef struct {
    logic        rst, ack, stall, ld;
    logic [31:0] data, tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ir, irpc;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(
    input logic r, a, s, l,
    input logic [31:0] d, t,
    input logic eq, input logic [31:0] ea,
    input logic ev, input logic [31:0] ei, ep);
    vec_t v;
    v.rst = r; v.ack = a; v.stall = s; v.ld = l;
    v.data = d; v.tgt = t;
    v.req = eq; v.addr = ea; v.vld = ev;
    v.ir = ei; v.irpc = ep;
    return v;
  endfunction

  function automatic logic [31:0] A(input int n);
    return 32'hA000_0000 + n;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, exp);
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s vec %0d: got %h want %h", nm, i, act, exp);
    end
  endtask

  initial begin
    logic [31:0] J;
    J = 32'hDEAD_BEEF;
    rst = 1; ack = 0; stall = 0; ld = 0; data = 0; tgt = 0;
    w_rst = 1; w_ack = 0; w_stall = 0; w_ld = 0;
    w_data = 0; w_tgt = 0;

    //            r a s l data   tgt    req addr vld ir    irpc
    tab.push_back(mk(1,0,0,0,0,    0,     0,0,    0,0,    0));
    tab.push_back(mk(0,0,0,0,0,    0,     1,0,    0,0,    0));
    tab.push_back(mk(0,1,0,0,A(0), 0,     0,0,    1,A(0), 0));
    tab.push_back(mk(0,0,0,0,0,    0,     1,4,    0,A(0), 0));
    tab.push_back(mk(0,1,0,0,A(1), 0,     0,0,    1,A(1), 4));
    tab.push_back(mk(0,0,0,0,0,    0,     1,8,    0,A(1), 4));
    tab.push_back(mk(0,1,0,0,A(2), 0,     0,0,    1,A(2), 8));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'hC,  0,A(2), 8));
    tab.push_back(mk(0,1,0,0,A(3), 0,     0,0,    1,A(3), 'hC));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h10, 0,A(3), 'hC));
    tab.push_back(mk(0,1,0,0,A(4), 0,     0,0,    1,A(4), 'h10));
    for (int k = 0; k < 5; k++)
      tab.push_back(mk(0,0,1,0,0,  0,     0,0,    1,A(4), 'h10));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h14, 0,A(4), 'h10));
    tab.push_back(mk(0,1,0,0,A(5), 0,     0,0,    1,A(5), 'h14));
    tab.push_back(mk(0,0,1,1,0,    'h40,  0,0,    0,A(5), 'h14));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h40, 0,A(5), 'h14));
    tab.push_back(mk(0,0,0,1,0,    'h200, 1,'h40, 0,A(5), 'h14));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h40, 0,A(5), 'h14));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h40, 0,A(5), 'h14));
    tab.push_back(mk(0,1,0,0,J,    0,     1,'h200,0,A(5), 'h14));
    tab.push_back(mk(0,1,0,0,A(6), 0,     0,0,    1,A(6), 'h200));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h204,0,A(6), 'h200));
    tab.push_back(mk(0,1,0,1,J,    'h103, 1,'h100,0,A(6), 'h200));
    tab.push_back(mk(0,1,0,0,A(7), 0,     0,0,    1,A(7), 'h100));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h104,0,A(7), 'h100));
    tab.push_back(mk(0,0,0,1,0,    'h300, 1,'h104,0,A(7), 'h100));
    tab.push_back(mk(0,0,0,1,0,    'h502, 1,'h104,0,A(7), 'h100));
    tab.push_back(mk(0,1,0,0,J,    0,     1,'h500,0,A(7), 'h100));
    tab.push_back(mk(0,1,0,0,A(8), 0,     0,0,    1,A(8), 'h500));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h504,0,A(8), 'h500));
    tab.push_back(mk(1,1,0,0,J,    0,     0,0,    0,0,    0));
    tab.push_back(mk(0,1,0,0,J,    0,     1,0,    0,0,    0));
    tab.push_back(mk(0,1,0,0,A(9), 0,     0,0,    1,A(9), 0));
    tab.push_back(mk(0,0,1,0,0,    0,     0,0,    1,A(9), 0));
    tab.push_back(mk(0,0,0,1,0,    'h80,  0,0,    0,A(9), 0));
    tab.push_back(mk(0,0,0,0,0,    0,     1,'h80, 0,A(9), 0));

    foreach (tab[i]) begin
      @(negedge clk);
      rst = tab[i].rst; ack = tab[i].ack; stall = tab[i].stall;
      ld = tab[i].ld; data = tab[i].data; tgt = tab[i].tgt;
      @(posedge clk);
      #1;
      nvec++;
      chk("imem_req", i, {31'd0, req}, {31'd0, tab[i].req});
      if (tab[i].req || tab[i].rst)
        chk("imem_addr", i, addr, tab[i].addr);
      chk("ir_valid", i, {31'd0, vld}, {31'd0, tab[i].vld});
      chk("ir", i, ir, tab[i].ir);
      chk("ir_pc", i, irpc, tab[i].irpc);
      chk("pc_plus4", i, p4, tab[i].irpc + 32'd4);
    end

    // Wrap instance: held in reset until now.
    @(negedge clk);
    w_rst = 1;
    @(posedge clk); #1; nvec++;
    chk("w_rst_req", 100, {31'd0, w_req}, 32'd0);
    chk("w_rst_addr", 100, w_addr, 32'hFFFF_FFFC);
    chk("w_rst_p4", 100, w_p4, 32'd4);
    @(negedge clk);
    w_rst = 0;
    @(posedge clk); #1; nvec++;
    chk("w_req", 101, {31'd0, w_req}, 32'd1);
    chk("w_addr", 101, w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_ack = 1; w_data = 32'h1234_5678;
    @(posedge clk); #1; nvec++;
    chk("w_ir_pc", 102, w_irpc, 32'hFFFF_FFFC);
    chk("w_pc_plus4", 102, w_p4, 32'h0000_0000);
    chk("w_ir", 102, w_ir, 32'h1234_5678);
    @(negedge clk);
    w_ack = 0;
    @(posedge clk); #1; nvec++;
    chk("w_next_req", 103, {31'd0, w_req}, 32'd1);
    chk("w_next_addr", 103, w_addr, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
